sram_port_arbiter: RTL and testbench
====================================

Name: sram_port_arbiter

Overview:
- Shares one asynchronous 32-bit SRAM bank between the CPU instruction-fetch port (read-only) and the data-memory port (read/write, byte enables).
- Sequences SRAM control strobes with parameterised wait states at 50 MHz and returns one-cycle completion pulses so the pipeline can stall.
- Sits between the CPU core and the board SRAM pins. The top level owns the tristate buffer: ram_data = ram_data_oe ? ram_data_o : 'z.

Parameters:
ADDR_W, 20, SRAM word-address width
DATA_W, 32, SRAM data width
READ_CYCLES, 2, cycles CE_n/OE_n held low per read (min 1; 0 is treated as 1)
WRITE_CYCLES, 2, cycles CE_n/WE_n held low per write (min 1; 0 is treated as 1)

Ports:
clk  in  1  system clock, 50 MHz
rst  in  1  synchronous, active-high reset
inst_req  in  1  fetch request; held with inst_addr until inst_done
inst_addr  in  ADDR_W  fetch word address
inst_done  out  1  one-cycle pulse, fetch complete
inst_rdata  out  DATA_W  fetch data, valid while inst_done=1
data_req  in  1  data request; held with addr/we/be/wdata until data_done
data_we  in  1  1 = write, 0 = read
data_addr  in  ADDR_W  data word address
data_be_n  in  4  byte enables, active low
data_wdata  in  DATA_W  write data
data_done  out  1  one-cycle pulse, data access complete
data_rdata  out  DATA_W  read data, valid while data_done=1
ram_addr  out  ADDR_W  SRAM address
ram_be_n  out  4  SRAM byte enables
ram_ce_n  out  1  SRAM chip enable
ram_oe_n  out  1  SRAM output enable
ram_we_n  out  1  SRAM write enable
ram_data_o  out  DATA_W  write data to pad
ram_data_oe  out  1  pad drive enable
ram_data_i  in  DATA_W  read data from pad

Behaviour:
- Reset values: state IDLE; ram_ce_n, ram_oe_n, ram_we_n = 1; ram_be_n = 4'hF; ram_addr = 0; ram_data_o = 0; ram_data_oe = 0; inst_done, data_done = 0; rdata registers = 0.
- All SRAM outputs and done pulses are registered; there are no combinational paths from req to pins.
- States: IDLE, READ, WRITE, DONE.
- IDLE arbitration:
  - data_req has fixed priority over inst_req, because MEM is older than IF.
  - The granted address is latched. be_n is latched as data_be_n for data accesses and 4'h0 for fetches. wdata is latched. The grant owner is latched.
  - Next state is WRITE if a data write is granted, otherwise READ.
  - With no request, the block stays in IDLE.
- READ:
  - ce_n = 0, oe_n = 0 for READ_CYCLES cycles, counted by a wait counter.
  - On the last READ cycle, ram_data_i is captured into the owner's rdata register.
  - Then DONE.
- WRITE:
  - ce_n = 0, we_n = 0, data_oe = 1 for WRITE_CYCLES cycles.
  - Then DONE.
- DONE (one cycle):
  - ce_n, oe_n, we_n = 1. The owner's done pulse is high.
  - data_oe stays 1 if the access was a write, giving data hold after the WE_n rising edge. It is 0 otherwise.
  - Requests are not sampled in DONE, because the requester still holds req this cycle. Next state is IDLE.
- Latency:
  - Requester asserts req in cycle 0 with the arbiter in IDLE.
  - Read: done is high in cycle READ_CYCLES+1.
  - Write: done is high in cycle WRITE_CYCLES+1.
  - Minimum spacing between accesses is READ_CYCLES+2 cycles (read) or WRITE_CYCLES+2 cycles (write).
- Both requests in the same IDLE cycle: data is served first. inst waits and is granted in the next IDLE, unless data_req is asserted again.
- req deasserted mid-access: the access still completes and done still pulses. Inputs are not re-sampled after the grant.
- Invariants: oe_n and we_n are never both 0. oe_n = 0 never coincides with data_oe = 1. rdata of the non-owner is unchanged.
- rst asserted mid-access: at the next edge all outputs return to reset values, we_n goes high, no done pulse is issued, and the access is abandoned.

Decomposition:
- Shared header sram_defs.vh holds the state encodings (IDLE = 0, READ = 1, WRITE = 2, DONE = 3) and the OWNER_INST/OWNER_DATA constants.
- Sub-module sram_wait_counter holds the load/decrement wait-state counter with a last-cycle flag. It is instantiated once and loaded with READ_CYCLES or WRITE_CYCLES on grant.
- Remaining RTL is a single FSM plus output registers, roughly 200 lines.

Test Plan:
- Single fetch: inst_req = 1, inst_addr = 0x00010, SRAM model returns 0x3C011234 -> ce_n/oe_n low cycles 1–2, inst_done = 1 in cycle 3 with inst_rdata = 0x3C011234, ram_be_n = 0.
- Byte write: data_we = 1, addr = 0x00020, be_n = 4'b1110, wdata = 0xAABBCCDD -> we_n low cycles 1–2, data_oe high cycles 1–3, data_done in cycle 3; model holds 0xDD in byte 0 only.
- Contention: inst_req and data_req (read 0x00030 = 0x11111111) rise together -> data_done in cycle 3, ce_n high cycle 3, inst grant cycle 4, inst_done in cycle 7.
- Held req across DONE: keep inst_req = 1 after inst_done -> exactly one new access starts in the IDLE cycle after DONE, with no double grant.
- Reset mid-write: rst = 1 in cycle 2 of a write -> we_n = 1, data_oe = 0, ce_n = 1 at the next edge; no data_done pulse.
- Parameter sweep READ_CYCLES = 1, WRITE_CYCLES = 3 -> read done in cycle 2, write done in cycle 4; oe_n/we_n never both low (assertion).

Source files
------------

// File: rtl/sram_port_arbiter_pkg.sv
// Shared types and constants for the SRAM port arbiter: FSM state encoding,
// grant-owner encoding and the wait-state load helper.
package sram_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef enum logic {
        OWNER_INST = 1'b0,
        OWNER_DATA = 1'b1
    } owner_t;

    localparam int BE_W = 4;
    localparam logic [BE_W-1:0] BE_NONE = 4'hF;
    localparam logic [BE_W-1:0] BE_ALL  = 4'h0;

    // Wide enough for any practical wait-state setting at 50 MHz.
    localparam int WAIT_W = 8;

    // A strobe must last at least one cycle, so 0 is promoted to 1.
    function automatic logic [WAIT_W-1:0] wait_load(input int cycles);
        if (cycles < 1) begin
            return WAIT_W'(1);
        end
        return WAIT_W'(cycles);
    endfunction

endpackage

// File: rtl/sram_wait_counter.sv
// Load/decrement wait-state counter; last is high during the final strobe cycle.
module sram_wait_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             dec,
    output logic             last
);

    logic [WIDTH-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_value;
        end else if (dec && (count_reg != '0)) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign last = (count_reg == WIDTH'(1));

endmodule

// File: rtl/sram_port_arbiter.sv
// Arbitrates the instruction-fetch and data ports onto one asynchronous SRAM,
// sequencing CE_n/OE_n/WE_n with wait states and returning done pulses.
module sram_port_arbiter
    import sram_port_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 20,
    parameter int DATA_W       = 32,
    parameter int READ_CYCLES  = 2,
    parameter int WRITE_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic              inst_done,
    output logic [DATA_W-1:0] inst_rdata,

    input  logic              data_req,
    input  logic              data_we,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [BE_W-1:0]   data_be_n,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_done,
    output logic [DATA_W-1:0] data_rdata,

    output logic [ADDR_W-1:0] ram_addr,
    output logic [BE_W-1:0]   ram_be_n,
    output logic              ram_ce_n,
    output logic              ram_oe_n,
    output logic              ram_we_n,
    output logic [DATA_W-1:0] ram_data_o,
    output logic              ram_data_oe,
    input  logic [DATA_W-1:0] ram_data_i
);

    localparam logic [WAIT_W-1:0] READ_LOAD  = wait_load(READ_CYCLES);
    localparam logic [WAIT_W-1:0] WRITE_LOAD = wait_load(WRITE_CYCLES);

    state_t            state_reg;
    owner_t            owner_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [BE_W-1:0]   be_n_reg;
    logic              ce_n_reg;
    logic              oe_n_reg;
    logic              we_n_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic              data_oe_reg;
    logic              inst_done_reg;
    logic              data_done_reg;
    logic [DATA_W-1:0] inst_rdata_reg;
    logic [DATA_W-1:0] data_rdata_reg;

    logic              grant;
    logic              grant_write;
    logic [WAIT_W-1:0] cnt_value;
    logic              cnt_dec;
    logic              cnt_last;

    // The counter is loaded in the grant cycle so it already holds the full
    // strobe length in the first READ/WRITE cycle.
    assign grant       = (state_reg == ST_IDLE) && (data_req || inst_req);
    assign grant_write = data_req && data_we;
    assign cnt_value   = grant_write ? WRITE_LOAD : READ_LOAD;
    assign cnt_dec     = (state_reg == ST_READ) || (state_reg == ST_WRITE);

    sram_wait_counter #(
        .WIDTH (WAIT_W)
    ) u_wait (
        .clk        (clk),
        .rst        (rst),
        .load       (grant),
        .load_value (cnt_value),
        .dec        (cnt_dec),
        .last       (cnt_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            owner_reg      <= OWNER_INST;
            addr_reg       <= '0;
            be_n_reg       <= BE_NONE;
            ce_n_reg       <= 1'b1;
            oe_n_reg       <= 1'b1;
            we_n_reg       <= 1'b1;
            wdata_reg      <= '0;
            data_oe_reg    <= 1'b0;
            inst_done_reg  <= 1'b0;
            data_done_reg  <= 1'b0;
            inst_rdata_reg <= '0;
            data_rdata_reg <= '0;
        end else begin
            inst_done_reg <= 1'b0;
            data_done_reg <= 1'b0;

            case (state_reg)
                ST_IDLE: begin
                    // Data port wins: the MEM stage is older than IF.
                    if (data_req) begin
                        owner_reg <= OWNER_DATA;
                        addr_reg  <= data_addr;
                        be_n_reg  <= data_be_n;
                        wdata_reg <= data_wdata;
                        ce_n_reg  <= 1'b0;
                        if (data_we) begin
                            we_n_reg    <= 1'b0;
                            data_oe_reg <= 1'b1;
                            state_reg   <= ST_WRITE;
                        end else begin
                            oe_n_reg  <= 1'b0;
                            state_reg <= ST_READ;
                        end
                    end else if (inst_req) begin
                        owner_reg <= OWNER_INST;
                        addr_reg  <= inst_addr;
                        be_n_reg  <= BE_ALL;
                        ce_n_reg  <= 1'b0;
                        oe_n_reg  <= 1'b0;
                        state_reg <= ST_READ;
                    end
                end

                ST_READ: begin
                    if (cnt_last) begin
                        if (owner_reg == OWNER_DATA) begin
                            data_rdata_reg <= ram_data_i;
                            data_done_reg  <= 1'b1;
                        end else begin
                            inst_rdata_reg <= ram_data_i;
                            inst_done_reg  <= 1'b1;
                        end
                        ce_n_reg  <= 1'b1;
                        oe_n_reg  <= 1'b1;
                        state_reg <= ST_DONE;
                    end
                end

                ST_WRITE: begin
                    // Pad drive stays on through DONE for data hold after WE_n rises.
                    if (cnt_last) begin
                        ce_n_reg      <= 1'b1;
                        we_n_reg      <= 1'b1;
                        data_done_reg <= 1'b1;
                        state_reg     <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    // Requests are ignored here: the requester still holds req.
                    data_oe_reg <= 1'b0;
                    state_reg   <= ST_IDLE;
                end

                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign inst_done   = inst_done_reg;
    assign inst_rdata  = inst_rdata_reg;
    assign data_done   = data_done_reg;
    assign data_rdata  = data_rdata_reg;
    assign ram_addr    = addr_reg;
    assign ram_be_n    = be_n_reg;
    assign ram_ce_n    = ce_n_reg;
    assign ram_oe_n    = oe_n_reg;
    assign ram_we_n    = we_n_reg;
    assign ram_data_o  = wdata_reg;
    assign ram_data_oe = data_oe_reg;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Scoreboard bench: two arbiter configurations, each with an SRAM model,
// directed scenarios and randomized traffic on both ports.
`timescale 1ns/1ps
module tb_sram_port_arbiter;

    typedef struct packed {
        logic        we;
        logic [31:0] rdata;
    } exp_t;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int fails  = 0;

    task automatic check(input int cfg, input string name,
                         input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL cfg%0d %s: got 0x%0h, required 0x%0h", cfg, name, act, req);
        end
    endtask

    for (genvar gi = 0; gi < 2; gi++) begin : g_cfg
        localparam int RC = (gi == 0) ? 2 : 1;
        localparam int WC = (gi == 0) ? 2 : 3;

        logic        rst;
        logic        inst_req;
        logic [19:0] inst_addr;
        logic        inst_done;
        logic [31:0] inst_rdata;
        logic        data_req;
        logic        data_we;
        logic [19:0] data_addr;
        logic [3:0]  data_be_n;
        logic [31:0] data_wdata;
        logic        data_done;
        logic [31:0] data_rdata;
        logic [19:0] ram_addr;
        logic [3:0]  ram_be_n;
        logic        ram_ce_n;
        logic        ram_oe_n;
        logic        ram_we_n;
        logic [31:0] ram_data_o;
        logic        ram_data_oe;
        logic [31:0] ram_data_i;

        logic [31:0] mem     [256];
        logic [31:0] ref_mem [256];
        exp_t        inst_q [$];
        exp_t        data_q [$];
        int          rd_cnt = 0;
        int          wr_cnt = 0;
        bit          fin = 1'b0;

        sram_port_arbiter #(
            .ADDR_W       (20),
            .DATA_W       (32),
            .READ_CYCLES  (RC),
            .WRITE_CYCLES (WC)
        ) dut (
            .clk         (clk),
            .rst         (rst),
            .inst_req    (inst_req),
            .inst_addr   (inst_addr),
            .inst_done   (inst_done),
            .inst_rdata  (inst_rdata),
            .data_req    (data_req),
            .data_we     (data_we),
            .data_addr   (data_addr),
            .data_be_n   (data_be_n),
            .data_wdata  (data_wdata),
            .data_done   (data_done),
            .data_rdata  (data_rdata),
            .ram_addr    (ram_addr),
            .ram_be_n    (ram_be_n),
            .ram_ce_n    (ram_ce_n),
            .ram_oe_n    (ram_oe_n),
            .ram_we_n    (ram_we_n),
            .ram_data_o  (ram_data_o),
            .ram_data_oe (ram_data_oe),
            .ram_data_i  (ram_data_i)
        );

        // Asynchronous SRAM: reads are combinational while CE_n/OE_n are low.
        assign ram_data_i = (!ram_ce_n && !ram_oe_n) ? mem[ram_addr[7:0]] : 32'hDEAD_BEEF;

        initial forever begin
            @(posedge clk);
            if (!ram_ce_n && !ram_we_n && ram_data_oe) begin
                for (int b = 0; b < 4; b++) begin
                    if (!ram_be_n[b]) mem[ram_addr[7:0]][8*b +: 8] = ram_data_o[8*b +: 8];
                end
            end
        end

        // Monitor: invariants every cycle, scoreboard pops on every done pulse.
        initial begin : monitor
            exp_t e;
            forever begin
                @(negedge clk);
                if (rst) begin
                    rd_cnt = 0;
                    wr_cnt = 0;
                end else begin
                    if (!ram_ce_n && !ram_oe_n) rd_cnt++;
                    if (!ram_ce_n && !ram_we_n) wr_cnt++;
                    check(gi, "oe_n and we_n both low", 32'(!ram_oe_n && !ram_we_n), 0);
                    check(gi, "oe_n low with data_oe", 32'(!ram_oe_n && ram_data_oe), 0);
                    check(gi, "we_n low without data_oe", 32'(!ram_we_n && !ram_data_oe), 0);
                    if (inst_done) begin
                        if (inst_q.size() == 0) begin
                            checks++;
                            fails++;
                            $display("FAIL cfg%0d spurious inst_done: got pulse, required none", gi);
                        end else begin
                            e = inst_q.pop_front();
                            check(gi, "inst_rdata", inst_rdata, e.rdata);
                            check(gi, "fetch strobe length", 32'(rd_cnt), 32'(RC));
                        end
                        rd_cnt = 0;
                    end
                    if (data_done) begin
                        if (data_q.size() == 0) begin
                            checks++;
                            fails++;
                            $display("FAIL cfg%0d spurious data_done: got pulse, required none", gi);
                        end else begin
                            e = data_q.pop_front();
                            if (e.we) begin
                                check(gi, "write strobe length", 32'(wr_cnt), 32'(WC));
                            end else begin
                                check(gi, "data_rdata", data_rdata, e.rdata);
                                check(gi, "data read strobe length", 32'(rd_cnt), 32'(RC));
                            end
                        end
                        rd_cnt = 0;
                        wr_cnt = 0;
                    end
                end
            end
        end

        // Waits (bounded) for a done pulse, checking the current cycle first.
        task automatic wait_port(input bit is_data, input int c0, output int lat);
            int n;
            n = 0;
            while (!(is_data ? data_done : inst_done) && n < 100) begin
                @(negedge clk);
                n++;
            end
            lat = (is_data ? data_done : inst_done) ? (cyc - c0) : -1;
        endtask

        initial begin : main
            int c0, lat, d_lat, i_lat, n, oe_cycles;
            logic [31:0] expw;
            exp_t e;

            for (int a = 0; a < 256; a++) begin
                mem[a] = (32'(a) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
            end
            mem[8'h10] = 32'h3C01_1234;
            mem[8'h30] = 32'h1111_1111;
            for (int a = 0; a < 256; a++) ref_mem[a] = mem[a];

            rst = 1'b1;
            inst_req = 1'b0;
            inst_addr = '0;
            data_req = 1'b0;
            data_we = 1'b0;
            data_addr = '0;
            data_be_n = 4'hF;
            data_wdata = '0;
            repeat (3) @(negedge clk);

            check(gi, "reset ram_ce_n", 32'(ram_ce_n), 1);
            check(gi, "reset ram_oe_n", 32'(ram_oe_n), 1);
            check(gi, "reset ram_we_n", 32'(ram_we_n), 1);
            check(gi, "reset ram_be_n", 32'(ram_be_n), 32'hF);
            check(gi, "reset ram_addr", 32'(ram_addr), 0);
            check(gi, "reset ram_data_o", ram_data_o, 0);
            check(gi, "reset ram_data_oe", 32'(ram_data_oe), 0);
            check(gi, "reset dones", {30'b0, inst_done, data_done}, 0);
            check(gi, "reset inst_rdata", inst_rdata, 0);
            check(gi, "reset data_rdata", data_rdata, 0);
            rst = 1'b0;
            @(negedge clk);

            // Single fetch
            inst_addr = 20'h00010;
            inst_req = 1'b1;
            c0 = cyc;
            e.we = 1'b0;
            e.rdata = ref_mem[8'h10];
            inst_q.push_back(e);
            @(negedge clk);
            check(gi, "fetch ram_be_n", 32'(ram_be_n), 0);
            check(gi, "fetch ram_addr", 32'(ram_addr), 32'h10);
            check(gi, "fetch ce_n/oe_n", {30'b0, ram_ce_n, ram_oe_n}, 0);
            wait_port(1'b0, c0, lat);
            check(gi, "fetch latency", 32'(lat), 32'(RC + 1));
            inst_req = 1'b0;
            @(negedge clk);

            // Byte write to lane 0 only
            data_we = 1'b1;
            data_addr = 20'h00020;
            data_be_n = 4'b1110;
            data_wdata = 32'hAABB_CCDD;
            data_req = 1'b1;
            c0 = cyc;
            expw = {ref_mem[8'h20][31:8], 8'hDD};
            ref_mem[8'h20] = expw;
            e.we = 1'b1;
            e.rdata = '0;
            data_q.push_back(e);
            oe_cycles = 0;
            n = 0;
            while (!data_done && n < 100) begin
                @(negedge clk);
                n++;
                if (ram_data_oe) oe_cycles++;
            end
            check(gi, "write latency", 32'(cyc - c0), 32'(WC + 1));
            data_req = 1'b0;
            @(negedge clk);
            if (ram_data_oe) oe_cycles++;
            check(gi, "write data_oe cycles", 32'(oe_cycles), 32'(WC + 1));
            check(gi, "byte write result", mem[8'h20], expw);

            // Contention: data read and fetch rise together
            data_we = 1'b0;
            data_addr = 20'h00030;
            inst_addr = 20'h00010;
            data_req = 1'b1;
            inst_req = 1'b1;
            c0 = cyc;
            e.we = 1'b0;
            e.rdata = ref_mem[8'h30];
            data_q.push_back(e);
            e.rdata = ref_mem[8'h10];
            inst_q.push_back(e);
            d_lat = -1;
            i_lat = -1;
            n = 0;
            while (i_lat < 0 && n < 100) begin
                @(negedge clk);
                n++;
                if (data_done) begin
                    d_lat = cyc - c0;
                    check(gi, "ce_n high at data done", 32'(ram_ce_n), 1);
                    data_req = 1'b0;
                end
                if (inst_done) begin
                    i_lat = cyc - c0;
                    inst_req = 1'b0;
                end
            end
            check(gi, "contention data latency", 32'(d_lat), 32'(RC + 1));
            check(gi, "contention inst latency", 32'(i_lat), 32'(2 * RC + 3));
            @(negedge clk);

            // Held fetch request across DONE: exactly one more access
            inst_addr = 20'h00045;
            inst_req = 1'b1;
            c0 = cyc;
            e.rdata = ref_mem[8'h45];
            inst_q.push_back(e);
            inst_q.push_back(e);
            wait_port(1'b0, c0, lat);
            check(gi, "held first latency", 32'(lat), 32'(RC + 1));
            c0 = cyc;
            @(negedge clk);
            wait_port(1'b0, c0, lat);
            check(gi, "held second spacing", 32'(lat), 32'(RC + 2));
            inst_req = 1'b0;
            n = 0;
            repeat (RC + 4) begin
                @(negedge clk);
                if (inst_done) n++;
            end
            check(gi, "held no extra grant", 32'(n), 0);

            // Randomized traffic on both ports
            fork
                begin : inst_drv
                    int a, l, c;
                    exp_t x;
                    repeat (60) begin
                        a = ($urandom_range(0, 7) == 0) ? 16 : 64 + $urandom_range(0, 63);
                        inst_addr = 20'(a);
                        inst_req = 1'b1;
                        x.we = 1'b0;
                        x.rdata = ref_mem[a];
                        inst_q.push_back(x);
                        c = cyc;
                        @(negedge clk);
                        wait_port(1'b0, c, l);
                        check(gi, "inst handshake", 32'(l > 0), 1);
                        if ($urandom_range(0, 1) == 1) begin
                            inst_req = 1'b0;
                            repeat ($urandom_range(1, 3)) @(negedge clk);
                        end
                    end
                    inst_req = 1'b0;
                end
                begin : data_drv
                    int a, l, c;
                    logic [3:0] be;
                    logic [31:0] wd;
                    exp_t x;
                    repeat (60) begin
                        if ($urandom_range(0, 1) == 1) begin
                            a = 128 + $urandom_range(0, 127);
                            be = 4'($urandom());
                            wd = $urandom();
                            data_we = 1'b1;
                            data_be_n = be;
                            data_wdata = wd;
                            for (int b = 0; b < 4; b++) begin
                                if (!be[b]) ref_mem[a][8*b +: 8] = wd[8*b +: 8];
                            end
                            x.we = 1'b1;
                            x.rdata = '0;
                        end else begin
                            a = $urandom_range(0, 255);
                            data_we = 1'b0;
                            x.we = 1'b0;
                            x.rdata = ref_mem[a];
                        end
                        data_addr = 20'(a);
                        data_req = 1'b1;
                        data_q.push_back(x);
                        c = cyc;
                        @(negedge clk);
                        wait_port(1'b1, c, l);
                        check(gi, "data handshake", 32'(l > 0), 1);
                        if ($urandom_range(0, 1) == 1) begin
                            data_req = 1'b0;
                            repeat ($urandom_range(1, 3)) @(negedge clk);
                        end
                    end
                    data_req = 1'b0;
                end
            join
            repeat (RC + WC + 4) @(negedge clk);
            check(gi, "inst queue drained", 32'(inst_q.size()), 0);
            check(gi, "data queue drained", 32'(data_q.size()), 0);

            // Reset in cycle 2 of a write abandons it without a done pulse
            data_we = 1'b1;
            data_addr = 20'h000A0;
            data_be_n = 4'h0;
            data_wdata = 32'h1234_5678;
            data_req = 1'b1;
            @(negedge clk);
            @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            check(gi, "rst mid-write we_n", 32'(ram_we_n), 1);
            check(gi, "rst mid-write ce_n", 32'(ram_ce_n), 1);
            check(gi, "rst mid-write data_oe", 32'(ram_data_oe), 0);
            check(gi, "rst mid-write data_done", 32'(data_done), 0);
            rst = 1'b0;
            data_req = 1'b0;
            n = 0;
            repeat (WC + 3) begin
                @(negedge clk);
                if (data_done) n++;
            end
            check(gi, "no done after abandoned write", 32'(n), 0);
            fin = 1'b1;
        end
    end

    initial begin : finisher
        int t;
        t = 0;
        while (!(g_cfg[0].fin && g_cfg[1].fin) && t < 20000) begin
            @(negedge clk);
            t++;
        end
        if (!(g_cfg[0].fin && g_cfg[1].fin)) begin
            checks++;
            fails++;
            $display("FAIL global timeout: got unfinished run after %0d cycles, required completion", t);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
